// File: rtl/generador_sonido.sv
// rtl/generador_sonido.sv - event-driven square-wave tone and melody generator
module generador_sonido #(
  parameter int HP_CUBO  = 56818,
  parameter int DUR_CUBO = 5000000,
  parameter int HP_N0    = 47778,
  parameter int HP_N1    = 63776,
  parameter int HP_N2    = 95556,
  parameter int DUR_NOTA = 12500000,
  parameter int CW       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       evento_cubo,
  input  logic       evento_final,
  output logic       sonido,
  output logic       ocupado,
  output logic [1:0] tipo_sonido
);

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    CUBO   = 3'd1,
    FIN_N0 = 3'd2,
    FIN_N1 = 3'd3,
    FIN_N2 = 3'd4
  } estado_t;

  // Terminal counter values, pre-truncated to the counter width.
  localparam logic [CW-1:0] DUR_CUBO_M1 = CW'(DUR_CUBO - 1);
  localparam logic [CW-1:0] DUR_NOTA_M1 = CW'(DUR_NOTA - 1);
  localparam logic [CW-1:0] HP_CUBO_M1  = CW'(HP_CUBO - 1);
  localparam logic [CW-1:0] HP_N0_M1    = CW'(HP_N0 - 1);
  localparam logic [CW-1:0] HP_N1_M1    = CW'(HP_N1 - 1);
  localparam logic [CW-1:0] HP_N2_M1    = CW'(HP_N2 - 1);

  estado_t       state_q, state_d;
  logic [CW-1:0] dur_q, dur_d;
  logic [CW-1:0] hp_q, hp_d;
  logic          sonido_q, sonido_d;
  logic          ocupado_q, ocupado_d;
  logic [1:0]    tipo_q, tipo_d;

  logic          entry;
  logic [CW-1:0] hp_term;

  // Next-state, counter and registered-output logic.
  // 'entry' marks any state (re)entry, which restarts both counters and the
  // waveform; REPOSO asserts it every cycle so counters sit at zero while idle.
  always_comb begin
    state_d = state_q;
    entry   = 1'b0;
    hp_term = HP_CUBO_M1;
    unique case (state_q)
      REPOSO: begin
        entry = 1'b1;
        if (evento_final)      state_d = FIN_N0;
        else if (evento_cubo)  state_d = CUBO;
      end
      CUBO: begin
        hp_term = HP_CUBO_M1;
        if (evento_final) begin
          state_d = FIN_N0;
          entry   = 1'b1;
        end else if (evento_cubo) begin
          state_d = CUBO;
          entry   = 1'b1;
        end else if (dur_q == DUR_CUBO_M1) begin
          state_d = REPOSO;
          entry   = 1'b1;
        end
      end
      FIN_N0: begin
        hp_term = HP_N0_M1;
        if (dur_q == DUR_NOTA_M1) begin
          state_d = FIN_N1;
          entry   = 1'b1;
        end
      end
      FIN_N1: begin
        hp_term = HP_N1_M1;
        if (dur_q == DUR_NOTA_M1) begin
          state_d = FIN_N2;
          entry   = 1'b1;
        end
      end
      FIN_N2: begin
        hp_term = HP_N2_M1;
        if (dur_q == DUR_NOTA_M1) begin
          state_d = REPOSO;
          entry   = 1'b1;
        end
      end
      default: begin
        state_d = REPOSO;
        entry   = 1'b1;
      end
    endcase

    if (entry) begin
      dur_d    = '0;
      hp_d     = '0;
      sonido_d = 1'b0;
    end else begin
      dur_d = dur_q + CW'(1);
      if (hp_q == hp_term) begin
        hp_d     = '0;
        sonido_d = ~sonido_q;
      end else begin
        hp_d     = hp_q + CW'(1);
        sonido_d = sonido_q;
      end
    end

    ocupado_d = (state_d != REPOSO);
    unique case (state_d)
      CUBO:                   tipo_d = 2'b01;
      FIN_N0, FIN_N1, FIN_N2: tipo_d = 2'b10;
      default:                tipo_d = 2'b00;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REPOSO;
      dur_q     <= '0;
      hp_q      <= '0;
      sonido_q  <= 1'b0;
      ocupado_q <= 1'b0;
      tipo_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      hp_q      <= hp_d;
      sonido_q  <= sonido_d;
      ocupado_q <= ocupado_d;
      tipo_q    <= tipo_d;
    end
  end

  assign sonido      = sonido_q;
  assign ocupado     = ocupado_q;
  assign tipo_sonido = tipo_q;

endmodule

// File: tb/tb_generador_sonido.sv
// tb/tb_generador_sonido.sv - scoreboard bench for generador_sonido
module tb_generador_sonido;

  localparam int HP_CUBO  = 4;
  localparam int DUR_CUBO = 40;
  localparam int HP_N0    = 3;
  localparam int HP_N1    = 5;
  localparam int HP_N2    = 7;
  localparam int DUR_NOTA = 30;
  localparam int CW       = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       evento_cubo = 1'b0;
  logic       evento_final = 1'b0;
  logic       sonido;
  logic       ocupado;
  logic [1:0] tipo_sonido;

  int total = 0;
  int bad = 0;

  // Expected outputs after one clock edge, packed as {sonido, ocupado, tipo}.
  logic [3:0] exp_q[$];

  // Reference model: mode 0 idle, 1 cube tone, 2 melody; e = cycles since start.
  int mode = 0;
  int e = 0;

  generador_sonido #(
    .HP_CUBO(HP_CUBO), .DUR_CUBO(DUR_CUBO), .HP_N0(HP_N0), .HP_N1(HP_N1),
    .HP_N2(HP_N2), .DUR_NOTA(DUR_NOTA), .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .evento_cubo(evento_cubo),
    .evento_final(evento_final),
    .sonido(sonido),
    .ocupado(ocupado),
    .tipo_sonido(tipo_sonido)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_out(input int m, input int el);
    int hp;
    int k;
    if (m == 1) begin
      return {logic'((el / HP_CUBO) % 2), 1'b1, 2'b01};
    end else if (m == 2) begin
      k  = el % DUR_NOTA;
      hp = (el / DUR_NOTA == 0) ? HP_N0 : (el / DUR_NOTA == 1) ? HP_N1 : HP_N2;
      return {logic'((k / hp) % 2), 1'b1, 2'b10};
    end
    return 4'b0000;
  endfunction

  // Advance the model by one clock edge with the given inputs and queue the result.
  task automatic step(input logic r, input logic c, input logic f);
    @(negedge clk);
    reset        = r;
    evento_cubo  = c;
    evento_final = f;
    if (r) begin
      mode = 0;
      e    = 0;
    end else if (f && mode != 2) begin
      mode = 2;
      e    = 0;
    end else if (c && mode != 2) begin
      mode = 1;
      e    = 0;
    end else if (mode != 0) begin
      e = e + 1;
      if ((mode == 1 && e == DUR_CUBO) || (mode == 2 && e == 3 * DUR_NOTA)) begin
        mode = 0;
        e    = 0;
      end
    end
    exp_q.push_back(model_out(mode, e));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle; compare after each edge.
  initial begin
    logic [3:0] ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        total++;
        if (sonido !== ex[3]) begin
          bad++;
          $display("FAIL sonido t=%0t got=%b want=%b", $time, sonido, ex[3]);
        end
        total++;
        if (ocupado !== ex[2]) begin
          bad++;
          $display("FAIL ocupado t=%0t got=%b want=%b", $time, ocupado, ex[2]);
        end
        total++;
        if (tipo_sonido !== ex[1:0]) begin
          bad++;
          $display("FAIL tipo_sonido t=%0t got=%b want=%b", $time, tipo_sonido, ex[1:0]);
        end
      end
    end
  end

  initial begin
    // 1: reset held with events toggling
    for (int i = 0; i < 5; i++) step(1'b1, logic'(i % 2), logic'((i + 1) % 2));
    idle(3);
    // 2: single cube tone
    step(1'b0, 1'b1, 1'b0);
    idle(50);
    // 3: full melody
    step(1'b0, 1'b0, 1'b1);
    idle(100);
    // 4: cube aborted by game over, cube pulses ignored during melody
    step(1'b0, 1'b1, 1'b0);
    idle(19);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      idle(9);
      step(1'b0, 1'b1, 1'b0);
    end
    idle(15);
    // 5: simultaneous events, then cube retrigger at cycle 30
    step(1'b0, 1'b1, 1'b1);
    idle(100);
    step(1'b0, 1'b1, 1'b0);
    idle(29);
    step(1'b0, 1'b1, 1'b0);
    idle(50);
    // 6: reset mid second note, then normal playback
    step(1'b0, 1'b0, 1'b1);
    idle(40);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0);
    idle(50);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 299) == 0),
           logic'($urandom_range(0, 24) == 0),
           logic'($urandom_range(0, 59) == 0));
    end
    idle(5);
    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
